pipe_hazard_ctrl: RTL and testbench

//  Hazard and forwarding controller for the decode/execute pipeline register.

---
 rtl/pipe_hazard_ctrl.sv | 95 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller with E/M destination shadows and a saturating stall counter.
// HAZ_FWD_EN: when defined, enables forwarding selects (only load-use stalls); otherwise any E/M hit interlocks.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              use_sa,
  input  logic              d_wreg,
  input  logic              d_m2reg,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              branch_taken,
  output logic [1:0]        adepend,
  output logic [1:0]        bdepend,
  output logic [1:0]        sdepend,
  output logic              stall,
  output logic              bubble,
  output logic              flush_fd,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              e_wreg, e_m2reg, m_wreg;
  logic [REG_AW-1:0] e_rd, m_rd;
`ifdef HAZ_FWD_EN
  logic              m_m2reg;
`endif

  // Register 0 is hardwired, so it can never be a real producer.
  function automatic logic hit(input logic w, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] src);
    return w && (rd == src) && (rd != '0);
  endfunction

  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  logic chk_rs;

  assign chk_rs   = use_rs | use_sa;
  assign e_hit_rs = hit(e_wreg, e_rd, rs);
  assign e_hit_rt = hit(e_wreg, e_rd, rt);
  assign m_hit_rs = hit(m_wreg, m_rd, rs);
  assign m_hit_rt = hit(m_wreg, m_rd, rt);

`ifdef HAZ_FWD_EN
  // Youngest producer wins; an E-stage load has no data yet and is caught by the stall.
  function automatic logic [1:0] fsel(input logic e_hit, input logic m_hit);
    if (e_hit && !e_m2reg) return 2'b01;
    if (m_hit)             return m_m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  assign adepend = use_rs ? fsel(e_hit_rs, m_hit_rs) : 2'b00;
  assign bdepend = use_rt ? fsel(e_hit_rt, m_hit_rt) : 2'b00;
  assign sdepend = use_sa ? fsel(e_hit_rs, m_hit_rs) : 2'b00;
  assign stall   = e_m2reg & ((chk_rs & e_hit_rs) | (use_rt & e_hit_rt));
`else
  assign adepend = 2'b00;
  assign bdepend = 2'b00;
  assign sdepend = 2'b00;
  assign stall   = (chk_rs & (e_hit_rs | m_hit_rs)) | (use_rt & (e_hit_rt | m_hit_rt));
`endif

  assign bubble   = stall;
  assign flush_fd = branch_taken & ~stall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_wreg    <= 1'b0;
      e_m2reg   <= 1'b0;
      e_rd      <= '0;
      m_wreg    <= 1'b0;
      m_rd      <= '0;
`ifdef HAZ_FWD_EN
      m_m2reg   <= 1'b0;
`endif
      stall_cnt <= '0;
    end else begin
      e_wreg  <= d_wreg & ~bubble;
      e_m2reg <= d_m2reg & ~bubble;
      e_rd    <= d_rd;
      m_wreg  <= e_wreg;
      m_rd    <= e_rd;
`ifdef HAZ_FWD_EN
      m_m2reg <= e_m2reg;
`endif
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: producer-history model checked every cycle plus directed literal checks.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0, clrn = 1'b0;
  logic [4:0]  rs = '0, rt = '0, d_rd = '0;
  logic        use_rs = 0, use_rt = 0, use_sa = 0, d_wreg = 0, d_m2reg = 0, branch_taken = 0;
  logic [1:0]  adepend, bdepend, sdepend;
  logic        stall, bubble, flush_fd;
  logic [15:0] stall_cnt;

  int tests = 0, fails = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .use_sa(use_sa), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_rd(d_rd),
    .branch_taken(branch_taken), .adepend(adepend), .bdepend(bdepend),
    .sdepend(sdepend), .stall(stall), .bubble(bubble), .flush_fd(flush_fd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Producers in flight: index 0 is the instruction issued one edge ago, 1 two edges ago.
  typedef struct { bit w; bit ld; logic [4:0] rd; } prod_t;
  prod_t st[2];
  int    mcnt;

  function automatic logic [1:0] src_sel(input logic [4:0] src, output bit need_stall);
    int y = -1;
    need_stall = 0;
    for (int i = 0; i < 2; i++)
      if (y < 0 && src != 0 && st[i].w && st[i].rd == src) y = i;
    if (y < 0) return 2'b00;
`ifdef HAZ_FWD_EN
    if (y == 0 && st[0].ld) begin need_stall = 1; return 2'b00; end
    if (y == 0) return 2'b01;
    return st[1].ld ? 2'b11 : 2'b10;
`else
    need_stall = 1;
    return 2'b00;
`endif
  endfunction

  function automatic void m_eval(output bit stl, output logic [1:0] a, output logic [1:0] b,
                                 output logic [1:0] s);
    bit sta, stb;
    logic [1:0] sa, sb;
    sa  = src_sel(rs, sta);
    sb  = src_sel(rt, stb);
    stl = ((use_rs | use_sa) & sta) | (use_rt & stb);
    a   = use_rs ? sa : 2'b00;
    b   = use_rt ? sb : 2'b00;
    s   = use_sa ? sa : 2'b00;
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st[0] = '{0, 0, 5'd0};
      st[1] = '{0, 0, 5'd0};
      mcnt  = 0;
    end else begin
      bit stl;
      logic [1:0] a, b, s;
      m_eval(stl, a, b, s);
      st[1] = st[0];
      st[0] = '{d_wreg && !stl, d_m2reg && !stl, d_rd};
      if (stl && mcnt < 65535) mcnt++;
    end
  end

  // Depend selects are don't-care while the instruction is being bubbled.
  always @(negedge clk) begin
    if (clrn) begin
      bit stl;
      logic [1:0] a, b, s;
      bit bad;
      m_eval(stl, a, b, s);
      bad = (stall !== stl) || (bubble !== stl) || (flush_fd !== (branch_taken & ~stl)) ||
            (stall_cnt !== 16'(mcnt)) ||
            (!stl && (adepend !== a || bdepend !== b || sdepend !== s));
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL model t=%0t: got st=%b bb=%b fl=%b cnt=%0d a=%b b=%b s=%b, want st=%b fl=%b cnt=%0d a=%b b=%b s=%b",
                 $time, stall, bubble, flush_fd, stall_cnt, adepend, bdepend, sdepend,
                 stl, branch_taken & ~stl, mcnt, a, b, s);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic ur,
                      input logic ut, input logic us, input logic dw, input logic dm,
                      input logic [4:0] drd, input logic br);
    rs = i_rs; rt = i_rt; use_rs = ur; use_rt = ut; use_sa = us;
    d_wreg = dw; d_m2reg = dm; d_rd = drd; branch_taken = br;
  endtask

  typedef struct { logic [4:0] rs, rt; logic ur, ut, us, dw, dm; logic [4:0] drd; } vec_t;
  vec_t vt[10];

  initial begin
    vt[0] = '{5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd4};
    vt[1] = '{5'd4, 5'd4, 1, 1, 1, 1, 1, 5'd6};
    vt[2] = '{5'd6, 5'd4, 0, 1, 1, 1, 0, 5'd7};
    vt[3] = '{5'd6, 5'd7, 1, 1, 0, 0, 0, 5'd7};
    vt[4] = '{5'd7, 5'd6, 0, 0, 1, 1, 1, 5'd7};
    vt[5] = '{5'd7, 5'd7, 1, 1, 1, 1, 0, 5'd0};
    vt[6] = '{5'd0, 5'd7, 1, 1, 1, 1, 0, 5'd9};
    vt[7] = '{5'd9, 5'd0, 1, 0, 0, 1, 1, 5'd9};
    vt[8] = '{5'd9, 5'd9, 0, 1, 1, 0, 0, 5'd2};
    vt[9] = '{5'd2, 5'd9, 1, 1, 0, 0, 0, 5'd0};

    #3;
    chk("reset_stall", stall, 0);
    chk("reset_cnt", stall_cnt, 0);
    chk("reset_dep", {adepend, bdepend, sdepend}, 0);
    chk("reset_flush", flush_fd, 0);
    tick();
    clrn = 1'b1;
    tick();

`ifdef HAZ_FWD_EN
    setd(0, 0, 0, 0, 0, 1, 0, 5'd5, 0); tick();
    setd(5'd5, 0, 1, 0, 0, 0, 0, 0, 0); #2;
    chk("alu_fwd_e", adepend, 2'b01);
    chk("alu_fwd_e_stall", stall, 0);
    tick(); #2;
    chk("alu_fwd_m", adepend, 2'b10);
    chk("alu_fwd_m_stall", stall, 0);
    setd(0, 0, 0, 0, 0, 1, 1, 5'd8, 0); tick();
    setd(0, 5'd8, 0, 1, 0, 0, 0, 0, 0); #2;
    chk("lu_stall", {stall, bubble}, 2'b11);
    tick(); #2;
    chk("lu_bdep", bdepend, 2'b11);
    chk("lu_stall_after", stall, 0);
    chk("lu_cnt", stall_cnt, 1);
`else
    setd(0, 0, 0, 0, 0, 1, 0, 5'd3, 0); tick();
    setd(5'd3, 0, 1, 0, 0, 0, 0, 0, 0); #2;
    chk("nofwd_stall1", stall, 1);
    chk("nofwd_adep", adepend, 0);
    tick(); #2;
    chk("nofwd_stall2", stall, 1);
    tick(); #2;
    chk("nofwd_stall3", stall, 0);
    chk("nofwd_cnt", stall_cnt, 2);
    setd(0, 0, 0, 0, 0, 1, 1, 5'd8, 0); tick();
    setd(0, 5'd8, 0, 1, 0, 0, 0, 0, 0); #2;
    chk("nofwd_lu_stall1", {stall, bubble}, 2'b11);
    tick(); #2;
    chk("nofwd_lu_stall2", stall, 1);
    tick(); #2;
    chk("nofwd_lu_clear", stall, 0);
    chk("nofwd_lu_cnt", stall_cnt, 4);
`endif

    setd(0, 0, 0, 0, 0, 1, 0, 5'd0, 0); tick();
    setd(0, 0, 1, 1, 1, 0, 0, 0, 0); #2;
    chk("r0_dep", {adepend, bdepend, sdepend}, 0);
    chk("r0_stall", stall, 0);
    tick();

    foreach (vt[i]) begin
      setd(vt[i].rs, vt[i].rt, vt[i].ur, vt[i].ut, vt[i].us, vt[i].dw, vt[i].dm, vt[i].drd, 0);
      tick();
    end
    setd(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();

    setd(0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    chk("br_flush", flush_fd, 1);
    setd(0, 0, 0, 0, 0, 1, 1, 5'd9, 0); tick();
    setd(5'd9, 0, 1, 0, 0, 0, 0, 0, 1); #2;
    chk("br_stalled_flush", flush_fd, 0);
    tick();
`ifndef HAZ_FWD_EN
    #2;
    chk("br_stalled_flush_m", flush_fd, 0);
    tick();
`endif
    #2;
    chk("br_flush_after", flush_fd, 1);

    setd(0, 0, 0, 0, 0, 1, 1, 5'd8, 0); tick();
    setd(0, 5'd8, 0, 1, 0, 0, 0, 0, 0); #2;
    chk("rst_pre_stall", stall, 1);
    clrn = 1'b0; #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    chk("rst_mid_dep", {adepend, bdepend, sdepend}, 0);
    tick();
    clrn = 1'b1;
    setd(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, expected finish before 50000");
    $fatal(1);
  end
endmodule
